// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : pipeline memory stage -- EX/MEM register, 16-bit data/stack
//                  memory, two-cycle PC push/pop sequencing, MEM/WB register.
// Revision: 1.0
// ============================================================================
module mem_stage_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Data,
  input  logic [31:0] Address,
  input  logic [2:0]  WB_Address,
  input  logic        MR,
  input  logic        MW,
  input  logic        WB,
  input  logic        JWSP,
  input  logic        Stack_PC,
  input  logic        Stack_Flags,
  input  logic        SP,
  input  logic        SPOP,
  input  logic [2:0]  Final_Flags,
  output logic        MEM_MR,
  output logic        MEM_Stack_Flags,
  output logic [2:0]  Flags_From_Memory,
  output logic        Stall,
  output logic        SP_Adjust,
  output logic        SP_Adjust_Inc,
  output logic [31:0] WB_Data,
  output logic [2:0]  WB_Address_Out,
  output logic        WB_En,
  output logic        PC_Load,
  output logic [31:0] PC_Value
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SECOND = 1'b1;

  logic [31:0]       m_data_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [2:0]        m_wb_addr_q;
  logic [2:0]        m_flags_q;
  logic              m_mr_q, m_mw_q, m_wb_q, m_jwsp_q, m_stack_pc_q, m_stack_flags_q;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] low_hold_q;
  logic [31:0]       wb_data_q, pc_value_q;
  logic [2:0]        wb_addr_q;
  logic              wb_en_q, pc_load_q;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  // SP/SPOP are consumed by EX; the upper address bits are outside the memory.
  logic unused_inputs;
  assign unused_inputs = ^{Address[31:ADDR_W], SP, SPOP};

  logic [ADDR_W-1:0] w_a_dn, w_a_up;
  logic              w_pc_push, w_pc_pop, w_flags_push, w_store, w_load, w_two, w_first;
  logic [DATA_W-1:0] w_rd, w_rd_up;
  logic [31:0]       w_popped, w_wb_data;

  assign w_a_dn       = m_addr_q - ADDR_W'(1);
  assign w_a_up       = m_addr_q + ADDR_W'(1);
  assign w_pc_push    = m_mw_q & m_stack_pc_q;
  assign w_pc_pop     = m_mr_q & ~m_mw_q & m_stack_pc_q;
  assign w_flags_push = m_mw_q & ~m_stack_pc_q & m_stack_flags_q;
  assign w_store      = m_mw_q & ~m_stack_pc_q & ~m_stack_flags_q;
  assign w_load       = m_mr_q & ~m_mw_q & ~m_stack_pc_q & ~m_stack_flags_q;
  assign w_two        = w_pc_push | w_pc_pop;
  assign w_first      = (state_q == S_IDLE) & w_two;

  assign w_rd     = mem_q[m_addr_q];
  assign w_rd_up  = mem_q[w_a_up];
  // Low word was captured in the first cycle; high word sits one address above.
  assign w_popped = {w_rd_up, low_hold_q};

  assign Stall             = w_first;
  assign SP_Adjust         = (state_q == S_SECOND) & w_two;
  assign SP_Adjust_Inc     = SP_Adjust & w_pc_pop;
  assign MEM_MR            = m_mr_q;
  assign MEM_Stack_Flags   = m_stack_flags_q;
  assign Flags_From_Memory = w_rd[2:0];
  assign WB_Data           = wb_data_q;
  assign WB_Address_Out    = wb_addr_q;
  assign WB_En             = wb_en_q;
  assign PC_Load           = pc_load_q;
  assign PC_Value          = pc_value_q;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = m_addr_q;
    w_wdata = m_data_q[DATA_W-1:0];
    if (w_pc_push) begin
      w_we = 1'b1;
      if (w_first) begin
        w_wdata = m_data_q[2*DATA_W-1:DATA_W];
      end else begin
        w_waddr = w_a_dn;
      end
    end else if (w_flags_push) begin
      w_we    = 1'b1;
      w_wdata = {{(DATA_W-3){1'b0}}, m_flags_q};
    end else if (w_store) begin
      w_we = 1'b1;
    end
  end

  always_comb begin
    w_wb_data = m_data_q;
    if (w_load) begin
      w_wb_data = {{(32-DATA_W){1'b0}}, w_rd};
    end else if (w_pc_pop) begin
      w_wb_data = w_popped;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (w_first) begin
      state_d = S_SECOND;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q        <= '0;
      m_addr_q        <= '0;
      m_wb_addr_q     <= '0;
      m_flags_q       <= '0;
      m_mr_q          <= 1'b0;
      m_mw_q          <= 1'b0;
      m_wb_q          <= 1'b0;
      m_jwsp_q        <= 1'b0;
      m_stack_pc_q    <= 1'b0;
      m_stack_flags_q <= 1'b0;
      state_q         <= S_IDLE;
      low_hold_q      <= '0;
      wb_data_q       <= '0;
      wb_addr_q       <= '0;
      wb_en_q         <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_value_q      <= '0;
    end else begin
      state_q <= state_d;
      if (!w_first) begin
        m_data_q        <= Data;
        m_addr_q        <= Address[ADDR_W-1:0];
        m_wb_addr_q     <= WB_Address;
        m_flags_q       <= Final_Flags;
        m_mr_q          <= MR;
        m_mw_q          <= MW;
        m_wb_q          <= WB;
        m_jwsp_q        <= JWSP;
        m_stack_pc_q    <= Stack_PC;
        m_stack_flags_q <= Stack_Flags;
      end
      if (w_first) begin
        // First half of a PC op: bubble into MEM/WB.
        wb_en_q   <= 1'b0;
        pc_load_q <= 1'b0;
        if (w_pc_pop) begin
          low_hold_q <= w_rd;
        end
      end else begin
        wb_en_q   <= m_wb_q & ~m_stack_pc_q & ~m_stack_flags_q;
        wb_addr_q <= m_wb_addr_q;
        wb_data_q <= w_wb_data;
        pc_load_q <= w_pc_pop & ~m_jwsp_q;
        if (w_pc_pop) begin
          pc_value_q <= w_popped;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// tb_mem_stage_ctrl : directed and randomized checks of mem_stage_ctrl against
// a word-array memory model and stack-frame rules.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Data = '0, Address = '0;
  logic [2:0]  WB_Address = '0, Final_Flags = '0;
  logic        MR = 1'b0, MW = 1'b0, WB = 1'b0, JWSP = 1'b0;
  logic        Stack_PC = 1'b0, Stack_Flags = 1'b0, SP = 1'b0, SPOP = 1'b0;
  logic        MEM_MR, MEM_Stack_Flags, Stall, SP_Adjust, SP_Adjust_Inc, WB_En, PC_Load;
  logic [2:0]  Flags_From_Memory, WB_Address_Out;
  logic [31:0] WB_Data, PC_Value;

  mem_stage_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Data(Data), .Address(Address), .WB_Address(WB_Address),
    .MR(MR), .MW(MW), .WB(WB), .JWSP(JWSP), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .SP(SP), .SPOP(SPOP), .Final_Flags(Final_Flags), .MEM_MR(MEM_MR),
    .MEM_Stack_Flags(MEM_Stack_Flags), .Flags_From_Memory(Flags_From_Memory),
    .Stall(Stall), .SP_Adjust(SP_Adjust), .SP_Adjust_Inc(SP_Adjust_Inc),
    .WB_Data(WB_Data), .WB_Address_Out(WB_Address_Out), .WB_En(WB_En),
    .PC_Load(PC_Load), .PC_Value(PC_Value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] mref [0:4095];
  bit          vld  [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit mr, mw, wb, jwsp, spc, sfl,
                       input logic [31:0] addr, data, input logic [2:0] wa, ff);
    MR = mr; MW = mw; WB = wb; JWSP = jwsp; Stack_PC = spc; Stack_Flags = sfl;
    Address = addr; Data = data; WB_Address = wa; Final_Flags = ff;
    SP = $urandom_range(0, 1); SPOP = $urandom_range(0, 1);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3'd0, 3'd0);
  endtask

  // One operation, issued alone, followed by a NOP; checks every visible effect.
  task automatic run_op(input bit mr, mw, wb, jwsp, spc, sfl,
                        input logic [31:0] addr, data, input logic [2:0] wa, ff);
    logic [11:0] a, a_up, a_dn;
    logic [31:0] exp_pop, exp_load;
    bit is_push, is_pop, is_two, is_load, is_fpop, is_pass;
    a = addr[11:0]; a_up = a + 12'd1; a_dn = a - 12'd1;
    is_push = mw & spc;
    is_pop  = mr & !mw & spc;
    is_two  = is_push | is_pop;
    is_load = mr & !mw & !spc & !sfl;
    is_fpop = mr & !mw & !spc & sfl;
    is_pass = !mr & !mw;
    exp_pop  = {mref[a_up], mref[a]};
    exp_load = {16'h0, mref[a]};

    drive(mr, mw, wb, jwsp, spc, sfl, addr, data, wa, ff);
    @(posedge clk); #1;
    chk("stall_first", Stall, is_two);
    chk("sp_adj_first", SP_Adjust, 0);
    chk("mem_mr", MEM_MR, mr);
    chk("mem_stack_flags", MEM_Stack_Flags, sfl);
    if (is_fpop && vld[a]) chk("flags_from_mem", Flags_From_Memory, mref[a][2:0]);
    if (is_two) begin
      @(posedge clk); #1;
      chk("stall_second", Stall, 0);
      chk("sp_adj_second", SP_Adjust, 1);
      chk("sp_adj_inc", SP_Adjust_Inc, is_pop);
      chk("mem_mr_held", MEM_MR, mr);
    end
    nop();
    @(posedge clk); #1;
    chk("wb_en", WB_En, wb & !spc & !sfl);
    chk("wb_addr", WB_Address_Out, wa);
    chk("pc_load", PC_Load, is_pop & !jwsp);
    chk("stall_after", Stall, 0);
    if (is_load && vld[a]) chk("wb_data_load", WB_Data, exp_load);
    if (is_pass) chk("wb_data_pass", WB_Data, data);
    if (is_pop && !jwsp && vld[a] && vld[a_up]) chk("pc_value", PC_Value, exp_pop);

    if (is_push) begin
      mref[a] = data[31:16];    vld[a] = 1'b1;
      mref[a_dn] = data[15:0];  vld[a_dn] = 1'b1;
    end else if (mw && sfl) begin
      mref[a] = {13'h0, ff};    vld[a] = 1'b1;
    end else if (mw) begin
      mref[a] = data[15:0];     vld[a] = 1'b1;
    end
  endtask

  logic [11:0] pool [0:7];
  logic [11:0] ra;
  logic [31:0] r32, rd;
  int          kind;

  initial begin
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h7FF; pool[3] = 12'h800;
    pool[4] = 12'hFFE; pool[5] = 12'hFFF; pool[6] = 12'h010; pool[7] = 12'h123;
    for (int i = 0; i < 4096; i++) vld[i] = 1'b0;

    // Reset state
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", Stall, 0);
    chk("rst_sp_adj", SP_Adjust, 0);
    chk("rst_wb_en", WB_En, 0);
    chk("rst_pc_load", PC_Load, 0);
    chk("rst_wb_data", WB_Data, 0);
    chk("rst_mem_mr", MEM_MR, 0);
    @(negedge clk); rst_n = 1'b1;

    // Store then load
    run_op(0, 1, 0, 0, 0, 0, 32'h0000_0010, 32'h0000_BEEF, 3'd0, 3'd0);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0010, 32'h0, 3'd3, 3'd0);
    chk("tp_load_beef", WB_Data, 32'h0000_BEEF);

    // PC push at top of memory, then RET pop
    run_op(0, 1, 0, 0, 1, 0, 32'h0000_0FFF, 32'h0001_2345, 3'd0, 3'd0);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0FFF, 32'h0, 3'd1, 3'd0);
    chk("tp_push_hi", WB_Data, 32'h0000_0001);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0FFE, 32'h0, 3'd2, 3'd0);
    chk("tp_push_lo", WB_Data, 32'h0000_2345);
    run_op(1, 0, 0, 0, 1, 0, 32'h0000_0FFE, 32'h0, 3'd0, 3'd0);
    chk("tp_ret_pc", PC_Value, 32'h0001_2345);

    // Wrap-around push at address 0
    run_op(0, 1, 0, 0, 1, 0, 32'h0000_0000, 32'hA1B2_C3D4, 3'd0, 3'd0);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0000, 32'h0, 3'd4, 3'd0);
    chk("tp_wrap_hi", WB_Data, 32'h0000_A1B2);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0FFF, 32'h0, 3'd5, 3'd0);
    chk("tp_wrap_lo", WB_Data, 32'h0000_C3D4);

    // Flags push/pop
    run_op(0, 1, 0, 0, 0, 1, 32'h0000_0800, 32'h0, 3'd0, 3'b101);
    run_op(1, 0, 1, 0, 0, 1, 32'h0000_0800, 32'h0, 3'd6, 3'd0);

    // Passthrough
    run_op(0, 0, 1, 0, 0, 0, 32'h0, 32'hDEAD_0042, 3'd7, 3'd0);

    // Randomized ops over boundary-heavy address pool
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      ra   = pool[$urandom_range(0, 7)];
      r32  = $urandom();
      rd   = $urandom();
      if ((kind == 1 || kind == 3) && !vld[ra]) kind = 0;
      if (kind == 5 && !(vld[ra] && vld[ra + 12'd1])) kind = 4;
      case (kind)
        0: run_op(0, 1, r32[0], 0, 0, 0, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
        1: run_op(1, 0, r32[0], 0, 0, 0, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
        2: run_op(0, 1, r32[0], 0, 0, 1, {r32[31:12], ra}, rd, r32[3:1], r32[6:4]);
        3: run_op(1, 0, r32[0], 0, 0, 1, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
        4: run_op(0, 1, r32[0], r32[7], 1, 0, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
        5: run_op(1, 0, r32[0], r32[7], 1, 0, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
        default: run_op(0, 0, r32[0], 0, 0, 0, {r32[31:12], ra}, rd, r32[3:1], 3'd0);
      endcase
    end

    // Async reset during the second cycle of a PC push
    run_op(0, 1, 0, 0, 0, 0, 32'h0000_0122, 32'h0000_A5A5, 3'd0, 3'd0);
    drive(0, 1, 1, 0, 1, 0, 32'h0000_0123, 32'hCAFE_F00D, 3'd2, 3'd0);
    @(posedge clk); #1;
    chk("rst_mid_stall1", Stall, 1);
    @(posedge clk); #1;
    chk("rst_mid_sp_adj", SP_Adjust, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", Stall, 0);
    chk("rst_mid_sp_adj0", SP_Adjust, 0);
    chk("rst_mid_inc", SP_Adjust_Inc, 0);
    chk("rst_mid_mem_mr", MEM_MR, 0);
    chk("rst_mid_wb_en", WB_En, 0);
    chk("rst_mid_pc_load", PC_Load, 0);
    chk("rst_mid_wb_addr", WB_Address_Out, 0);
    chk("rst_mid_pc_value", PC_Value, 0);
    nop();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    mref[12'h123] = 16'hCAFE; vld[12'h123] = 1'b1;
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0122, 32'h0, 3'd1, 3'd0);
    chk("rst_mid_no_low_write", WB_Data, 32'h0000_A5A5);
    run_op(1, 0, 1, 0, 0, 0, 32'h0000_0123, 32'h0, 3'd1, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage pipeline: holds the EX/MEM pipeline register, owns the 16-bit-wide data/stack memory, and drives the MEM/WB register.
- Single-word loads and stores complete in one cycle.
- 32-bit PC push/pop (CALL/RET/interrupt) uses two memory cycles, stalls upstream stages and issues the extra stack-pointer step.
- Supplies flags popped from the stack back to the execution stage.

Parameters:
ADDR_W, 12, memory address width; depth = 2^ADDR_W words of 16 bits
DATA_W, 16, memory word width (fixed at 16; 32-bit values span two words)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
Data  in  32  store data / PC to push (EX result)
Address  in  32  memory address or stack address from EX; low ADDR_W bits used
WB_Address  in  3  destination register
MR, MW, WB, JWSP, Stack_PC, Stack_Flags, SP, SPOP  in  1 each  EX/MEM control bits
Final_Flags  in  3  {NF,CF,ZF} from EX
MEM_MR  out  1  registered MR of the op in the stage
MEM_Stack_Flags  out  1  registered Stack_Flags of the op in the stage
Flags_From_Memory  out  3  mem[M_Address][2:0], combinational
Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
SP_Adjust  out  1  one-cycle pulse: step stack pointer once more
SP_Adjust_Inc  out  1  direction of SP_Adjust; 1 = +1, 0 = -1
WB_Data  out  32  MEM/WB data
WB_Address_Out  out  3  MEM/WB destination
WB_En  out  1  MEM/WB register-write enable
PC_Load  out  1  popped PC valid, from a RET (JWSP=0 pop)
PC_Value  out  32  popped PC

Behaviour:
- Reset (async, rst_n=0):
  - All EX/MEM and MEM/WB registers clear to 0; FSM returns to IDLE; Low_Hold = 0.
  - Stall, SP_Adjust, WB_En and PC_Load are 0.
  - Memory contents are not reset.
  - Reset mid two-word op abandons it; no partial write is completed.
- EX/MEM register (M_*): captures all inputs on the posedge when Stall=0; holds when Stall=1.
- Address: A = M_Address[ADDR_W-1:0]. A-1 and A+1 wrap modulo 2^ADDR_W.
- Memory: write is synchronous on the posedge; read is asynchronous.
- Op decode on M_* (MW has priority if MR and MW are both set):
  - STORE (MW, !Stack_PC, !Stack_Flags): mem[A] <= Data[15:0]. One cycle.
  - FLAGS PUSH (MW & Stack_Flags): mem[A] <= {13'b0, Final_Flags}. One cycle.
  - LOAD (MR, !Stack_PC, !Stack_Flags): WB_Data <= {16'b0, mem[A]}. One cycle.
  - FLAGS POP (MR & Stack_Flags): no WB. MEM_MR and MEM_Stack_Flags expose the op so EX selects Flags_From_Memory.
  - PC PUSH (MW & Stack_PC): two cycles.
  - PC POP (MR & Stack_PC): two cycles.
  - No MR/MW: passthrough, WB_Data <= M_Data. One cycle.
- FSM states: IDLE, SECOND.
  - IDLE with a two-word op: Stall=1; next state SECOND.
  - SECOND: Stall=0; next state IDLE; the EX/MEM register loads the next op at that edge.
  - PC PUSH:
    - IDLE cycle: mem[A] <= M_Data[31:16].
    - SECOND cycle: mem[A-1] <= M_Data[15:0]; SP_Adjust=1, SP_Adjust_Inc=0.
  - PC POP:
    - IDLE cycle: Low_Hold <= mem[A].
    - SECOND cycle: result = {mem[A+1], Low_Hold}; SP_Adjust=1, SP_Adjust_Inc=1.
  - Resulting stack layout: high word at the higher address; each PC frame moves SP by 2 in total.
- MEM/WB register:
  - Loads at the end of the op's last cycle; latency is 1 cycle for single-word ops, 2 for PC ops.
  - During the IDLE cycle of a two-word op, WB_En <= 0 (bubble).
  - WB_En <= M_WB & !Stack_PC & !Stack_Flags; WB_Address_Out <= M_WB_Address.
  - PC_Load <= 1 for one cycle after a PC POP with M_JWSP=0, with PC_Value = popped word.
- MEM_MR and MEM_Stack_Flags are the M_* registers; they hold while Stall=1.

Test Plan:
- Store then load: MW, Address=0x0010, Data=0x0000BEEF; next cycle MR, Address=0x0010, WB=1, WB_Address=3 -> two cycles later WB_En=1, WB_Data=0x0000BEEF, WB_Address_Out=3.
- PC push: MW, Stack_PC, Address=0x0FFF, Data=0x00012345 -> Stall=1 for one cycle; mem[0x0FFF]=0x0001, mem[0x0FFE]=0x2345; SP_Adjust pulse with Inc=0; EX/MEM held through the stall.
- PC pop (RET): MR, Stack_PC, JWSP=0, Address=0x0FFE -> Stall one cycle, SP_Adjust Inc=1, then PC_Load=1, PC_Value=0x00012345, WB_En=0.
- Wrap-around: PC push at Address=0x0000 -> high word to 0x0000, low word to 0x0FFF.
- Flags push/pop: push Final_Flags=3'b101 at 0x0800; pop at 0x0800 -> MEM_MR=1, MEM_Stack_Flags=1, Flags_From_Memory=3'b101, no stall.
- Async reset asserted during the SECOND cycle of a PC push -> Stall=0 and FSM in IDLE immediately; mem[A-1] unchanged; all outputs 0.
